// File: rtl/inst_mem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: default widths,
// enable constants, slot state encoding and round-robin pointer encoding.
package inst_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  typedef enum logic {
    PRIO_FETCH = 1'b0,
    PRIO_DEBUG = 1'b1
  } prio_e;

  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/inst_mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the instruction ROM.
// The slave modport is the arbiter side, master is the requester/ROM side.
interface inst_mem_arbiter_if #(
  parameter int ADDR_W = inst_mem_arbiter_pkg::ADDR_W_DEF,
  parameter int DATA_W = inst_mem_arbiter_pkg::DATA_W_DEF
) ();

  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic [DATA_W-1:0] f_rdata;
  logic              f_rvalid;
  logic              f_rready;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_gnt;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvalid;
  logic              d_rready;

  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  logic              err_align;

  modport slave (
    input  f_req, f_addr, f_rready,
    output f_gnt, f_rdata, f_rvalid,
    input  d_req, d_addr, d_rready,
    output d_gnt, d_rdata, d_rvalid,
    output rom_ce, rom_addr,
    input  rom_data,
    output err_align
  );

  modport master (
    output f_req, f_addr, f_rready,
    input  f_gnt, f_rdata, f_rvalid,
    output d_req, d_addr, d_rready,
    input  d_gnt, d_rdata, d_rvalid,
    input  rom_ce, rom_addr,
    output rom_data,
    input  err_align
  );

endinterface

// File: rtl/inst_mem_arbiter_slot.sv
// Single-entry response register with valid/ready handshake; free_o tells the
// arbiter the slot can accept a new word this cycle (empty or being drained).
module inst_arb_slot
  import inst_mem_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rready_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  output logic              free_o
);

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      EMPTY: if (load_i) state_d = FULL;
      FULL: begin
        if (load_i)        state_d = FULL;
        else if (rready_i) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (load_i) data_d = wdata_i;
  end

  assign rdata_o  = data_q;
  assign rvalid_o = (state_q == FULL);
  assign free_o   = (state_q == EMPTY) || rready_i;

endmodule

// File: rtl/inst_mem_arbiter.sv
// Two-port round-robin arbiter in front of a combinational instruction ROM.
// Define INST_ARB_DEBUG_EN to compile in the debug/loader port and round-robin.
module inst_mem_arbiter
  import inst_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic               clk,
  input logic               rst,
  inst_mem_arbiter_if.slave bus
);

  logic fSlotFree;
  logic fGnt;
  logic dGnt;
  logic errAlign_q, errAlign_d;

  inst_arb_slot #(.DATA_W(DATA_W)) uFetchSlot (
    .clk      (clk),
    .rst      (rst),
    .load_i   (fGnt),
    .wdata_i  (bus.rom_data),
    .rready_i (bus.f_rready),
    .rdata_o  (bus.f_rdata),
    .rvalid_o (bus.f_rvalid),
    .free_o   (fSlotFree)
  );

`ifdef INST_ARB_DEBUG_EN
  logic  dSlotFree;
  logic  fElig, dElig;
  prio_e prio_q, prio_d;

  inst_arb_slot #(.DATA_W(DATA_W)) uDebugSlot (
    .clk      (clk),
    .rst      (rst),
    .load_i   (dGnt),
    .wdata_i  (bus.rom_data),
    .rready_i (bus.d_rready),
    .rdata_o  (bus.d_rdata),
    .rvalid_o (bus.d_rvalid),
    .free_o   (dSlotFree)
  );

  // Pointer names the port that wins the next tie: the one not granted last.
  always_comb begin
    fElig  = bus.f_req && fSlotFree;
    dElig  = bus.d_req && dSlotFree;
    fGnt   = !rst && fElig && (!dElig || prio_q == PRIO_FETCH);
    dGnt   = !rst && dElig && !fGnt;
    prio_d = prio_q;
    if (fGnt)      prio_d = PRIO_DEBUG;
    else if (dGnt) prio_d = PRIO_FETCH;
  end

  always_ff @(posedge clk) begin
    if (rst) prio_q <= PRIO_FETCH;
    else     prio_q <= prio_d;
  end
`else
  logic unusedDebugIn;

  assign fGnt          = !rst && bus.f_req && fSlotFree;
  assign dGnt          = DISABLE;
  assign bus.d_rvalid  = DISABLE;
  assign bus.d_rdata   = '0;
  assign unusedDebugIn = ^{bus.d_req, bus.d_addr, bus.d_rready};
`endif

  assign bus.f_gnt = fGnt;
  assign bus.d_gnt = dGnt;

  always_comb begin
    bus.rom_ce   = fGnt || dGnt;
    bus.rom_addr = '0;
    errAlign_d   = DISABLE;
    if (fGnt) begin
      bus.rom_addr = bus.f_addr;
      errAlign_d   = misaligned(bus.f_addr[1:0]);
    end else if (dGnt) begin
      bus.rom_addr = bus.d_addr;
      errAlign_d   = misaligned(bus.d_addr[1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) errAlign_q <= DISABLE;
    else     errAlign_q <= errAlign_d;
  end

  assign bus.err_align = errAlign_q;

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Directed bench for inst_mem_arbiter: a vector table for the fetch path plus
// hand-written sequences whose content depends on INST_ARB_DEBUG_EN.
module tb_inst_mem_arbiter;

  typedef struct {
    logic        rst;
    logic        fReq;
    logic [31:0] fAddr;
    logic        fRready;
    logic        dReq;
    logic [31:0] dAddr;
    logic        expGnt;
    logic [31:0] expRomAddr;
    logic        expRvalid;
    logic [31:0] expData;
    logic        expErr;
  } vec_t;

  logic clk;
  logic rst;
  int   errCount;
  int   checkCount;
  vec_t vecs[15];

  inst_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  inst_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] romWord(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.rom_data = romWord(bus.rom_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic r, input logic fq, input logic [31:0] fa,
                              input logic frr, input logic dq, input logic [31:0] da,
                              input logic g, input logic [31:0] ra, input logic rv,
                              input logic [31:0] dataAddr, input logic err);
    vec_t v;
    v.rst = r; v.fReq = fq; v.fAddr = fa; v.fRready = frr; v.dReq = dq; v.dAddr = da;
    v.expGnt = g; v.expRomAddr = ra; v.expRvalid = rv;
    v.expData = rv ? romWord(dataAddr) : 32'h0;
    v.expErr = err;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic fq, input logic [31:0] fa,
                               input logic frr, input logic dq, input logic [31:0] da,
                               input logic drr);
    @(negedge clk);
    rst = r;
    bus.f_req = fq; bus.f_addr = fa; bus.f_rready = frr;
    bus.d_req = dq; bus.d_addr = da; bus.d_rready = drr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    errCount = 0;
    checkCount = 0;
    rst = 1'b1;
    bus.f_req = 1'b0; bus.f_addr = '0; bus.f_rready = 1'b0;
    bus.d_req = 1'b0; bus.d_addr = '0; bus.d_rready = 1'b0;

    // Fetch-path vectors; rows with rvalid=0 also expect rdata=0 only after reset.
    vecs[0]  = mk(1, 1, 32'h10, 1, 1, 32'h20, 0, 32'h0,  0, 32'h0,  0);
    vecs[1]  = mk(0, 1, 32'h10, 1, 1, 32'h20, 1, 32'h10, 1, 32'h10, 0);
    vecs[2]  = mk(0, 1, 32'h14, 1, 0, 32'h0,  1, 32'h14, 1, 32'h14, 0);
    vecs[3]  = mk(0, 1, 32'h18, 1, 0, 32'h0,  1, 32'h18, 1, 32'h18, 0);
    vecs[4]  = mk(0, 1, 32'h1A, 1, 0, 32'h0,  1, 32'h1A, 1, 32'h1A, 1);
    vecs[5]  = mk(0, 0, 32'h0,  1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0);
    vecs[6]  = mk(0, 1, 32'h20, 0, 0, 32'h0,  1, 32'h20, 1, 32'h20, 0);
    vecs[7]  = mk(0, 1, 32'h24, 0, 0, 32'h0,  0, 32'h0,  1, 32'h20, 0);
    vecs[8]  = mk(0, 1, 32'h24, 0, 0, 32'h0,  0, 32'h0,  1, 32'h20, 0);
    vecs[9]  = mk(0, 1, 32'h24, 1, 0, 32'h0,  1, 32'h24, 1, 32'h24, 0);
    vecs[10] = mk(0, 0, 32'h0,  0, 0, 32'h0,  0, 32'h0,  1, 32'h24, 0);
    vecs[11] = mk(0, 0, 32'h0,  1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0);
    vecs[12] = mk(0, 1, 32'h30, 1, 0, 32'h0,  1, 32'h30, 1, 32'h30, 0);
    vecs[13] = mk(1, 1, 32'h34, 1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0);
    vecs[14] = mk(0, 0, 32'h0,  1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].fReq, vecs[i].fAddr, vecs[i].fRready,
                    vecs[i].dReq, vecs[i].dAddr, 1'b1);
      checkOutput($sformatf("v%0d f_gnt", i), 32'(bus.f_gnt), 32'(vecs[i].expGnt));
      checkOutput($sformatf("v%0d d_gnt", i), 32'(bus.d_gnt), 32'h0);
      checkOutput($sformatf("v%0d rom_ce", i), 32'(bus.rom_ce), 32'(vecs[i].expGnt));
      checkOutput($sformatf("v%0d rom_addr", i), bus.rom_addr, vecs[i].expRomAddr);
      tick();
      checkOutput($sformatf("v%0d f_rvalid", i), 32'(bus.f_rvalid), 32'(vecs[i].expRvalid));
      if (vecs[i].expRvalid || vecs[i].rst)
        checkOutput($sformatf("v%0d f_rdata", i), bus.f_rdata, vecs[i].expData);
      checkOutput($sformatf("v%0d d_rvalid", i), 32'(bus.d_rvalid), 32'h0);
      checkOutput($sformatf("v%0d err_align", i), 32'(bus.err_align), 32'(vecs[i].expErr));
    end

`ifdef INST_ARB_DEBUG_EN
    // Contention alternates fetch, debug, fetch, debug starting from reset priority.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 32'h50, 1, 1, 32'h90, 1);
      checkOutput($sformatf("alt%0d f_gnt", i), 32'(bus.f_gnt), 32'(i % 2 == 0));
      checkOutput($sformatf("alt%0d d_gnt", i), 32'(bus.d_gnt), 32'(i % 2 == 1));
      checkOutput($sformatf("alt%0d rom_ce", i), 32'(bus.rom_ce), 32'h1);
      checkOutput($sformatf("alt%0d rom_addr", i), bus.rom_addr, (i % 2 == 0) ? 32'h50 : 32'h90);
      tick();
      if (i % 2 == 0) checkOutput($sformatf("alt%0d f_rdata", i), bus.f_rdata, romWord(32'h50));
      else            checkOutput($sformatf("alt%0d d_rdata", i), bus.d_rdata, romWord(32'h90));
    end

    applyStimulus(0, 0, 32'h0, 1, 1, 32'h6, 1);
    checkOutput("mis d_gnt", 32'(bus.d_gnt), 32'h1);
    checkOutput("mis rom_addr", bus.rom_addr, 32'h6);
    tick();
    checkOutput("mis d_rvalid", 32'(bus.d_rvalid), 32'h1);
    checkOutput("mis d_rdata", bus.d_rdata, romWord(32'h6));
    checkOutput("mis err_align", 32'(bus.err_align), 32'h1);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0, 1);
    tick();
    checkOutput("mis err_align clear", 32'(bus.err_align), 32'h0);
    checkOutput("mis d_rvalid clear", 32'(bus.d_rvalid), 32'h0);

    // Reset right after a fetch grant must drop the response and restore fetch priority.
    applyStimulus(0, 1, 32'h60, 1, 0, 32'h0, 1);
    checkOutput("rst pre f_gnt", 32'(bus.f_gnt), 32'h1);
    tick();
    applyStimulus(1, 1, 32'h60, 1, 1, 32'h70, 1);
    checkOutput("rst f_gnt", 32'(bus.f_gnt), 32'h0);
    checkOutput("rst d_gnt", 32'(bus.d_gnt), 32'h0);
    tick();
    checkOutput("rst f_rvalid", 32'(bus.f_rvalid), 32'h0);
    checkOutput("rst d_rvalid", 32'(bus.d_rvalid), 32'h0);
    applyStimulus(0, 1, 32'h60, 1, 1, 32'h70, 1);
    checkOutput("post rst f_gnt", 32'(bus.f_gnt), 32'h1);
    checkOutput("post rst d_gnt", 32'(bus.d_gnt), 32'h0);
    tick();
    checkOutput("post rst f_rvalid", 32'(bus.f_rvalid), 32'h1);
`else
    // Debug port compiled out: constant d_req is ignored, fetch streams one word per cycle.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 32'h40 + 32'(4 * i), 1, 1, 32'h80, 1);
      checkOutput($sformatf("nodbg%0d f_gnt", i), 32'(bus.f_gnt), 32'h1);
      checkOutput($sformatf("nodbg%0d d_gnt", i), 32'(bus.d_gnt), 32'h0);
      checkOutput($sformatf("nodbg%0d rom_addr", i), bus.rom_addr, 32'h40 + 32'(4 * i));
      tick();
      checkOutput($sformatf("nodbg%0d f_rvalid", i), 32'(bus.f_rvalid), 32'h1);
      checkOutput($sformatf("nodbg%0d f_rdata", i), bus.f_rdata, romWord(32'h40 + 32'(4 * i)));
      checkOutput($sformatf("nodbg%0d d_rvalid", i), 32'(bus.d_rvalid), 32'h0);
      checkOutput($sformatf("nodbg%0d d_rdata", i), bus.d_rdata, 32'h0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/inst_mem_arbiter.md
INST_MEM_ARBITER -- requirements
Module: inst_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: instruction ROM byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32: instruction word width (4 ROM bytes).
REQ-003 SHALL have ports: clk  input  1  sole clock, rising edge; rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: f_req  input  1; f_addr  input  ADDR_W; f_gnt  output  1; f_rdata  output  DATA_W; f_rvalid  output  1; f_rready  input  1 (fetch port).
REQ-005 SHALL have ports: d_req  input  1; d_addr  input  ADDR_W; d_gnt  output  1; d_rdata  output  DATA_W; d_rvalid  output  1; d_rready  input  1 (debug/loader port).
REQ-006 SHALL have ports: rom_ce  output  1; rom_addr  output  ADDR_W; rom_data  input  DATA_W (to combinational instruction ROM).
REQ-007 SHALL have port: err_align  output  1, one-cycle pulse on a misaligned granted access.

Function
REQ-008 SHALL grant at most one port per cycle; a port is eligible only when its req=1 and its response slot is empty or being drained this cycle (rvalid=1 and rready=1).
REQ-009 SHALL grant combinationally in the cycle of the request; gnt, rom_ce=1 and rom_addr=granted addr SHALL coincide.
REQ-010 SHALL drive rom_ce=0 and rom_addr=0 in every cycle with no grant, so the ROM is never read idly.
REQ-011 SHALL arbitrate round-robin: on contention, grant the port not granted most recently; after reset, fetch has priority.
REQ-012 SHALL capture rom_data into the granted port's rdata register at the granting edge; rvalid SHALL rise exactly one cycle after gnt (latency 1).
REQ-013 SHALL hold rdata and rvalid stable while rvalid=1 and rready=0; the slot SHALL clear on the edge where rvalid=1 and rready=1 unless refilled the same edge.
REQ-014 SHALL sustain one access per cycle per port (back-to-back) when rready stays 1.
REQ-015 Per-port state machine SHALL be EMPTY -> FULL on grant; FULL -> EMPTY on drain without grant; FULL -> FULL on drain plus grant; FULL held otherwise.
REQ-016 SHALL treat an access with addr[1:0] != 0 as granted and answered normally, and SHALL pulse err_align in the grant cycle +1.
REQ-017 A requester SHALL hold req and addr until it sees gnt; the block SHALL not queue ungranted requests.

Reset
REQ-018 On rst=1 at a clock edge: f_rvalid=d_rvalid=0, f_rdata=d_rdata=0, err_align=0, round-robin pointer=fetch; gnt outputs and rom_ce SHALL be 0 while rst=1.
REQ-019 Reset mid-access SHALL discard any in-flight or held response without producing rvalid.

Configuration
REQ-020 Macro INST_ARB_DEBUG_EN SHALL compile in the debug port and round-robin logic.
REQ-021 Without INST_ARB_DEBUG_EN: d_gnt=0, d_rvalid=0, d_rdata=0 constantly, d_req/d_addr/d_rready ignored, fetch always eligible under REQ-008; port list unchanged.

Structure
REQ-022 Shared package/header SHALL hold ADDR_W/DATA_W defaults, ENABLE/DISABLE constants and the port-slot state encoding (EMPTY, FULL).
REQ-023 A sub-module inst_arb_slot (one response register with valid/ready handshake) SHALL be instantiated once per port.

Verification
REQ-024 Reset then f_req=1, f_addr=0x0000_0010, f_rready=1 -> f_gnt=1, rom_ce=1, rom_addr=0x10 same cycle; next cycle f_rvalid=1, f_rdata=ROM word at 0x10.
REQ-025 f_req and d_req held high for 4 cycles, both rready=1 -> grants alternate F,D,F,D; rom_ce=1 every cycle.
REQ-026 f_req=1 for 3 cycles, f_rready=0 -> one grant only, f_rdata held constant 2 cycles; raise f_rready -> next grant in the drain cycle.
REQ-027 d_addr=0x0000_0006 granted -> d_rvalid next cycle and err_align=1 for exactly one cycle.
REQ-028 rst asserted the cycle after a grant -> no rvalid appears; first post-reset contention grants fetch.
REQ-029 Build without INST_ARB_DEBUG_EN, d_req=1 constant -> d_gnt and d_rvalid stay 0; fetch back-to-back throughput 1 word/cycle.
